hpi_access_sequencer: RTL and testbench
=======================================

// Module: hpi_access_sequencer
// PURPOSE
// Shares the CY7C67200 HPI port between two requesters. Port 0 is the Nios II
// software PIO path; port 1 is a hardware keycode poller. The block sits between
// the requesters and hpi_io_intf (from_sw_* side). It arbitrates round-robin and
// runs each granted access as a timed chip cycle: setup, strobe, hold.
// PARAMETERS
// SETUP_CYC   2   Clk cycles with CS_N low and address valid, before the strobe (>=1)
// STROBE_CYC  4   Clk cycles with RD_N or WR_N low (>=1)
// HOLD_CYC    1   Clk cycles with CS_N low after the strobe rises (>=1)
// PORTS
// Clk          in   1   system clock (CLOCK_50)
// Reset_n      in   1   synchronous, active-low reset
// req0/req1    in   1   access request, held high until ack
// we0/we1      in   1   1=write, 0=read; sampled at grant
// addr0/addr1  in   2   HPI register address; sampled at grant
// wdata0/wdata1 in  16  write data; sampled at grant
// ack0/ack1    out  1   one-cycle pulse when that requester's access completes
// rdata        out  16  read data; valid in the ack cycle and held until the next read completes
// busy         out  1   high in every state except IDLE
// hpi_addr     out  2   to hpi_io_intf from_sw_address
// hpi_data_out out  16  to hpi_io_intf from_sw_data_in (chip-bound write data)
// hpi_data_in  in   16  from hpi_io_intf from_sw_data_out
// hpi_r_n      out  1   read strobe, active low
// hpi_w_n      out  1   write strobe, active low
// hpi_cs_n     out  1   chip select, active low
// BEHAVIOUR
// - Reset (Reset_n=0 at a rising Clk edge): state=IDLE; hpi_cs_n=hpi_r_n=hpi_w_n=1;
//   hpi_addr=0; hpi_data_out=0; rdata=0; ack0=ack1=0; busy=0; last_grant=1.
//   Reset wins from any state. An access cut off by reset is dropped and never acked.
// - FSM states: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
// - IDLE: all strobes high. A request is present when req0|req1.
//   - Only one req high: grant it.
//   - Both high: grant the port that is not last_grant.
//   - On grant: latch we, addr, wdata and the grant id; update last_grant; go to SETUP.
//   - No request: stay in IDLE.
// - SETUP: hpi_cs_n=0, hpi_addr=latched addr, hpi_data_out=latched wdata.
//   Stays SETUP_CYC cycles.
// - STROBE: hpi_cs_n=0, plus hpi_r_n=0 (read) or hpi_w_n=0 (write). Stays STROBE_CYC cycles.
//   - Read: on the last STROBE cycle, register hpi_data_in into rdata.
// - HOLD: strobes high, hpi_cs_n=0, addr and data unchanged. Stays HOLD_CYC cycles.
// - DONE: hpi_cs_n=1; ack of the granted port =1 for exactly this cycle; next state IDLE.
// - hpi_r_n and hpi_w_n are never low together.
// - hpi_cs_n is low from the first SETUP cycle through the last HOLD cycle, with no gaps.
// - Outputs are registered, with no combinational path from req to hpi_*.
// - Latency from IDLE with req high to the ack cycle is 1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
//   With the defaults that is 8 cycles, and the ack is visible in the 9th cycle.
// - req is sampled only in IDLE:
//   - req dropped mid-access: the access still completes and is acked.
//   - req still high in the cycle after ack: a new access starts.
// - A single down-counter, width $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1), is reloaded
//   on every state entry. Reaching 1 advances the state.
// - Back-to-back accesses: the minimum hpi_cs_n-high gap is 2 cycles (DONE + IDLE).
// TESTING
// 1) Reset: hold Reset_n=0 for 3 cycles with req0=1 -> cs_n/r_n/w_n=1, ack0=0, busy=0.
// 2) Single write: req0=1, we0=1, addr0=2, wdata0=16'h1234.
//    -> cs_n low 7 cycles, w_n low 4 cycles, data_out=16'h1234, ack0 8 cycles after grant.
// 3) Single read: req1=1, we1=0, addr1=0; drive hpi_data_in=16'hBEEF during STROBE
//    -> rdata=16'hBEEF at ack1; r_n low 4 cycles; w_n stays 1.
// 4) Contention: req0 and req1 rise on the same cycle just after reset -> port 0 served
//    first, then port 1. Keep both high for 4 accesses -> grant order 0,1,0,1.
// 5) req0 pulsed high for 1 cycle only -> full access still runs and ack0 pulses once.
// 6) Reset_n=0 during STROBE -> next cycle cs_n=r_n=1, state IDLE, no ack generated.

Source files
------------

// File: rtl/hpi_access_sequencer.sv
// Round-robin sharing of the CY7C67200 HPI port (port 0 = SW PIO, port 1 = keycode poller); each grant runs SETUP/STROBE/HOLD then a 1-cycle ack.
// Latency 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles from grant to ack; requesters hold req until ack, and req is only sampled in IDLE.
module hpi_access_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r_n,
    output logic        hpi_w_n,
    output logic        hpi_cs_n
);

    localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  next_cnt;

    logic           grant_vld;
    logic           grant_id;
    logic           last_grant;
    logic           gnt_q;
    logic           we_q;

    logic           cs_n_d;
    logic           r_n_d;
    logic           w_n_d;
    logic           ack0_d;
    logic           ack1_d;
    logic           busy_d;

    // State register and phase counter; the counter is reloaded on each state entry.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        grant_vld  = 1'b0;
        grant_id   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_vld  = 1'b1;
                    grant_id   = (req0 && req1) ? ~last_grant : req1;
                    next_state = S_SETUP;
                    next_cnt   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt == CNT_ONE) begin
                    next_state = S_STROBE;
                    next_cnt   = STROBE_LD;
                end else begin
                    next_cnt = cnt - CNT_ONE;
                end
            end
            S_STROBE: begin
                if (cnt == CNT_ONE) begin
                    next_state = S_HOLD;
                    next_cnt   = HOLD_LD;
                end else begin
                    next_cnt = cnt - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt == CNT_ONE) begin
                    next_state = S_DONE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt - CNT_ONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
                next_cnt   = '0;
            end
            default: begin
                next_state = S_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Decoded from next_state so the flops below present each state's pins during that state.
    always_comb begin
        cs_n_d = 1'b1;
        r_n_d  = 1'b1;
        w_n_d  = 1'b1;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        busy_d = (next_state != S_IDLE);
        case (next_state)
            S_SETUP: cs_n_d = 1'b0;
            S_STROBE: begin
                cs_n_d = 1'b0;
                r_n_d  = we_q;
                w_n_d  = ~we_q;
            end
            S_HOLD: cs_n_d = 1'b0;
            S_DONE: begin
                ack0_d = ~gnt_q;
                ack1_d = gnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            last_grant   <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            hpi_addr     <= '0;
            hpi_data_out <= '0;
            rdata        <= '0;
            hpi_cs_n     <= 1'b1;
            hpi_r_n      <= 1'b1;
            hpi_w_n      <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (grant_vld) begin
                last_grant   <= grant_id;
                gnt_q        <= grant_id;
                we_q         <= grant_id ? we1 : we0;
                hpi_addr     <= grant_id ? addr1 : addr0;
                hpi_data_out <= grant_id ? wdata1 : wdata0;
            end
            if ((state == S_STROBE) && (cnt == CNT_ONE) && !we_q) begin
                rdata <= hpi_data_in;
            end
            hpi_cs_n <= cs_n_d;
            hpi_r_n  <= r_n_d;
            hpi_w_n  <= w_n_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Directed plus randomized bench for hpi_access_sequencer; expected pin waveforms come from cycle offsets relative to the grant edge.
module tb_hpi_access_sequencer;

    logic        Clk;
    logic        Reset_n;
    logic        req0, req1;
    logic        we0, we1;
    logic [1:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata;
    logic        busy;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_data_out;
    logic [15:0] hpi_data_in;
    logic        hpi_r_n, hpi_w_n, hpi_cs_n;

    int          checks = 0;
    int          errors = 0;
    bit          model_last;
    logic [15:0] model_rdata;

    hpi_access_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack0         (ack0),
        .ack1         (ack1),
        .rdata        (rdata),
        .busy         (busy),
        .hpi_addr     (hpi_addr),
        .hpi_data_out (hpi_data_out),
        .hpi_data_in  (hpi_data_in),
        .hpi_r_n      (hpi_r_n),
        .hpi_w_n      (hpi_w_n),
        .hpi_cs_n     (hpi_cs_n)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " cs_n"}, hpi_cs_n, 1);
        check({tag, " r_n"}, hpi_r_n, 1);
        check({tag, " w_n"}, hpi_w_n, 1);
        check({tag, " ack0"}, ack0, 0);
        check({tag, " ack1"}, ack1, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    task automatic raise(input bit port);
        if (port == 1'b0) begin
            req0 = 1'b1; we0 = 1'($urandom); addr0 = 2'($urandom); wdata0 = 16'($urandom);
        end else begin
            req1 = 1'b1; we1 = 1'($urandom); addr1 = 2'($urandom); wdata1 = 16'($urandom);
        end
    endtask

    // Called at a negedge while the DUT is idle; the next posedge is the grant.
    // k counts negedges after the grant: 1..2 setup, 3..6 strobe, 7 hold, 8 ack, 9 idle.
    // drop_mode: 0 = release req at ack, 1 = release right after grant, 2 = keep req high.
    task automatic access(input bit port, input bit we, input logic [1:0] addr,
                          input logic [15:0] wd, input int drop_mode,
                          input bit force_din, input logic [15:0] din_val);
        logic [15:0] cap;
        bit          strobe;
        cap = model_rdata;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            strobe = (k >= 3) && (k <= 6);
            check($sformatf("cs_n p%0d k%0d", port, k), hpi_cs_n, (k <= 7) ? 0 : 1);
            check($sformatf("w_n p%0d k%0d", port, k), hpi_w_n, (we && strobe) ? 0 : 1);
            check($sformatf("r_n p%0d k%0d", port, k), hpi_r_n, (!we && strobe) ? 0 : 1);
            check($sformatf("ack0 p%0d k%0d", port, k), ack0, (k == 8 && port == 1'b0) ? 1 : 0);
            check($sformatf("ack1 p%0d k%0d", port, k), ack1, (k == 8 && port == 1'b1) ? 1 : 0);
            check($sformatf("busy p%0d k%0d", port, k), busy, (k <= 8) ? 1 : 0);
            if (k <= 7) begin
                check($sformatf("addr p%0d k%0d", port, k), hpi_addr, addr);
                check($sformatf("dout p%0d k%0d", port, k), hpi_data_out, wd);
            end
            if (k == 1) check($sformatf("rdata held p%0d", port), rdata, model_rdata);
            if (k == 8) begin
                if (!we) model_rdata = cap;
                check($sformatf("rdata ack p%0d", port), rdata, model_rdata);
            end
            if (k == 9) check($sformatf("rdata kept p%0d", port), rdata, model_rdata);
            hpi_data_in = (force_din && strobe) ? din_val : 16'($urandom);
            if (k == 6) cap = hpi_data_in;
            if (k <= 7) begin
                if (port == 1'b0) begin
                    we0 = 1'($urandom); addr0 = 2'($urandom); wdata0 = 16'($urandom);
                end else begin
                    we1 = 1'($urandom); addr1 = 2'($urandom); wdata1 = 16'($urandom);
                end
            end
            if ((k == 1 && drop_mode == 1) || (k == 8 && drop_mode == 0)) begin
                if (port == 1'b0) req0 = 1'b0;
                else              req1 = 1'b0;
            end
        end
    endtask

    // Round-robin reference: a lone requester wins, otherwise the port not served last.
    task automatic serve(input int drop_mode, input bit force_din, input logic [15:0] din_val);
        bit p;
        if (req0 && req1) p = ~model_last;
        else              p = req1;
        model_last = p;
        if (p == 1'b0) access(1'b0, we0, addr0, wdata0, drop_mode, force_din, din_val);
        else           access(1'b1, we1, addr1, wdata1, drop_mode, force_din, din_val);
    endtask

    initial begin
        Reset_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 16'h1234;
        req1 = 1'b0; we1 = 1'b0; addr1 = 2'd0; wdata1 = 16'h0000;
        hpi_data_in = 16'h0000;
        model_last  = 1'b1;
        model_rdata = 16'h0000;

        // Reset held three cycles with a pending request.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_idle($sformatf("reset c%0d", i));
            check($sformatf("reset rdata c%0d", i), rdata, 0);
            check($sformatf("reset addr c%0d", i), hpi_addr, 0);
            check($sformatf("reset dout c%0d", i), hpi_data_out, 0);
        end
        Reset_n = 1'b1;

        // Single write from port 0.
        serve(0, 1'b0, 16'h0000);

        // Single read from port 1 with fixed chip data.
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
        serve(0, 1'b1, 16'hBEEF);
        check("read beef", rdata, 16'hBEEF);

        // One-cycle request pulse still runs a full access.
        raise(1'b0);
        serve(1, 1'b0, 16'h0000);

        // Contention straight out of reset, both held for four accesses.
        Reset_n = 1'b0;
        raise(1'b0);
        raise(1'b1);
        @(negedge Clk);
        check_idle("contention reset");
        Reset_n = 1'b1;
        model_last  = 1'b1;
        model_rdata = 16'h0000;
        repeat (4) serve(2, 1'b0, 16'h0000);
        req0 = 1'b0;
        req1 = 1'b0;

        // Reset during the strobe drops the access without an ack.
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3; wdata1 = 16'h5A5A;
        repeat (4) @(negedge Clk);
        check("mid strobe r_n", hpi_r_n, 0);
        Reset_n = 1'b0;
        req1 = 1'b0;
        @(negedge Clk);
        check_idle("strobe reset");
        check("strobe reset rdata", rdata, 0);
        Reset_n = 1'b1;
        model_last  = 1'b1;
        model_rdata = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check_idle($sformatf("after reset c%0d", i));
        end

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!req0 && $urandom_range(0, 1) == 1) raise(1'b0);
            if (!req1 && $urandom_range(0, 1) == 1) raise(1'b1);
            if (!req0 && !req1) raise(1'($urandom));
            serve(int'($urandom_range(0, 2)), 1'b0, 16'h0000);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge Clk);
        check_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
